// File: rtl/multi_clock_event_collector.sv
// Synchronizes two foreign-clock levels into clk, counts their rising edges
// with saturation, and presents each event as a ready/valid record.
module multi_clock_event_collector #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             io_result_A,
    input  logic             io_result_B,
    input  logic             io_clear,
    input  logic             io_out_ready,
    output logic             io_out_valid,
    output logic             io_out_bits_src,
    output logic [CNT_W-1:0] io_out_bits_count,
    output logic [CNT_W-1:0] io_count_A,
    output logic [CNT_W-1:0] io_count_B,
    output logic             io_sat,
    output logic             io_drop
);

    localparam int unsigned LAST = SYNC_STAGES - 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    out_state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_a_q, sync_b_q;
    logic                   prev_a_q, prev_b_q;

    logic [CNT_W-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
    logic             slot_a_v_q, slot_a_v_d, slot_b_v_q, slot_b_v_d;
    logic [CNT_W-1:0] slot_a_cnt_q, slot_a_cnt_d, slot_b_cnt_q, slot_b_cnt_d;
    logic             src_q, src_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic             sat_q, sat_d, drop_q, drop_d;
    // 1 = B is preferred on the next contended load
    logic             ptr_q, ptr_d;

    logic             rise_a, rise_b;
    logic             load_en, sel_b, take_a, take_b;
    logic [CNT_W-1:0] cnt_a_inc, cnt_b_inc;

    // Level synchronizers and previous-value flops; never cleared by io_clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_a_q <= '0;
            sync_b_q <= '0;
            prev_a_q <= 1'b0;
            prev_b_q <= 1'b0;
        end else begin
            sync_a_q <= {sync_a_q[SYNC_STAGES-2:0], io_result_A};
            sync_b_q <= {sync_b_q[SYNC_STAGES-2:0], io_result_B};
            prev_a_q <= sync_a_q[LAST];
            prev_b_q <= sync_b_q[LAST];
        end
    end

    // State, counters, slots, output record and sticky flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= OUT_EMPTY;
            cnt_a_q      <= '0;
            cnt_b_q      <= '0;
            slot_a_v_q   <= 1'b0;
            slot_b_v_q   <= 1'b0;
            slot_a_cnt_q <= '0;
            slot_b_cnt_q <= '0;
            src_q        <= 1'b0;
            out_cnt_q    <= '0;
            sat_q        <= 1'b0;
            drop_q       <= 1'b0;
            ptr_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_a_q      <= cnt_a_d;
            cnt_b_q      <= cnt_b_d;
            slot_a_v_q   <= slot_a_v_d;
            slot_b_v_q   <= slot_b_v_d;
            slot_a_cnt_q <= slot_a_cnt_d;
            slot_b_cnt_q <= slot_b_cnt_d;
            src_q        <= src_d;
            out_cnt_q    <= out_cnt_d;
            sat_q        <= sat_d;
            drop_q       <= drop_d;
            ptr_q        <= ptr_d;
        end
    end

    // Next-state: edge detect, counting, slot management, arbitration, output FSM
    always_comb begin
        state_d      = state_q;
        cnt_a_d      = cnt_a_q;
        cnt_b_d      = cnt_b_q;
        slot_a_v_d   = slot_a_v_q;
        slot_b_v_d   = slot_b_v_q;
        slot_a_cnt_d = slot_a_cnt_q;
        slot_b_cnt_d = slot_b_cnt_q;
        src_d        = src_q;
        out_cnt_d    = out_cnt_q;
        sat_d        = sat_q;
        drop_d       = drop_q;
        ptr_d        = ptr_q;

        rise_a = sync_a_q[LAST] & ~prev_a_q;
        rise_b = sync_b_q[LAST] & ~prev_b_q;

        cnt_a_inc = (cnt_a_q == CNT_MAX) ? cnt_a_q : cnt_a_q + CNT_W'(1);
        cnt_b_inc = (cnt_b_q == CNT_MAX) ? cnt_b_q : cnt_b_q + CNT_W'(1);

        // Output can take a new record when empty or completing a handshake
        load_en = (slot_a_v_q | slot_b_v_q) &
                  ((state_q == OUT_EMPTY) | io_out_ready);
        sel_b   = slot_b_v_q & (~slot_a_v_q | ptr_q);
        take_a  = load_en & ~sel_b;
        take_b  = load_en & sel_b;

        if (io_clear) begin
            state_d      = OUT_EMPTY;
            cnt_a_d      = '0;
            cnt_b_d      = '0;
            slot_a_v_d   = 1'b0;
            slot_b_v_d   = 1'b0;
            slot_a_cnt_d = '0;
            slot_b_cnt_d = '0;
            src_d        = 1'b0;
            out_cnt_d    = '0;
            sat_d        = 1'b0;
            drop_d       = 1'b0;
        end else begin
            // Output register
            if (load_en) begin
                state_d   = OUT_FULL;
                src_d     = sel_b;
                out_cnt_d = sel_b ? slot_b_cnt_q : slot_a_cnt_q;
                // Pointer advances only when it actually resolves a contention
                if (slot_a_v_q && slot_b_v_q) begin
                    ptr_d = ~sel_b;
                end
            end else if ((state_q == OUT_FULL) && io_out_ready) begin
                state_d = OUT_EMPTY;
            end

            if (take_a) begin
                slot_a_v_d = 1'b0;
            end
            if (take_b) begin
                slot_b_v_d = 1'b0;
            end

            // Source A event
            if (rise_a) begin
                cnt_a_d = cnt_a_inc;
                if (cnt_a_q == CNT_MAX) begin
                    sat_d = 1'b1;
                end
                if (!slot_a_v_q || take_a) begin
                    slot_a_v_d   = 1'b1;
                    slot_a_cnt_d = cnt_a_inc;
                end else begin
                    drop_d = 1'b1;
                end
            end

            // Source B event
            if (rise_b) begin
                cnt_b_d = cnt_b_inc;
                if (cnt_b_q == CNT_MAX) begin
                    sat_d = 1'b1;
                end
                if (!slot_b_v_q || take_b) begin
                    slot_b_v_d   = 1'b1;
                    slot_b_cnt_d = cnt_b_inc;
                end else begin
                    drop_d = 1'b1;
                end
            end
        end
    end

    assign io_out_valid      = (state_q == OUT_FULL);
    assign io_out_bits_src   = src_q;
    assign io_out_bits_count = out_cnt_q;
    assign io_count_A        = cnt_a_q;
    assign io_count_B        = cnt_b_q;
    assign io_sat            = sat_q;
    assign io_drop           = drop_q;

endmodule

// File: tb/tb_multi_clock_event_collector.sv
// Directed bench for multi_clock_event_collector with a record scoreboard.
module tb_multi_clock_event_collector;

    typedef struct packed {
        logic       src;
        logic [7:0] cnt;
    } rec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       a, b, clr, rdy;
    logic       valid, src, sat, drop;
    logic [7:0] cnt, cnt_a, cnt_b;

    logic       a2, b2, clr2, rdy2;
    logic       valid2, src2, sat2, drop2;
    logic [1:0] cnt2, cnt_a2, cnt_b2;

    rec_t q[$];
    rec_t q2[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    multi_clock_event_collector #(.SYNC_STAGES(2), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .io_result_A(a), .io_result_B(b),
        .io_clear(clr), .io_out_ready(rdy), .io_out_valid(valid),
        .io_out_bits_src(src), .io_out_bits_count(cnt),
        .io_count_A(cnt_a), .io_count_B(cnt_b), .io_sat(sat), .io_drop(drop)
    );

    multi_clock_event_collector #(.SYNC_STAGES(2), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .io_result_A(a2), .io_result_B(b2),
        .io_clear(clr2), .io_out_ready(rdy2), .io_out_valid(valid2),
        .io_out_bits_src(src2), .io_out_bits_count(cnt2),
        .io_count_A(cnt_a2), .io_count_B(cnt_b2), .io_sat(sat2), .io_drop(drop2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic s, input logic [7:0] c);
        chk({tag, "_valid"}, 32'(valid), 32'(v));
        chk({tag, "_src"}, 32'(src), 32'(s));
        chk({tag, "_count"}, 32'(cnt), 32'(c));
    endtask

    // Scoreboard for the 8-bit instance: pop on each accepted handshake
    always @(negedge clk) begin
        if (reset && valid && rdy) begin
            chk("sb_nonempty", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                rec_t e;
                e = q.pop_front();
                chk("rec_src", 32'(src), 32'(e.src));
                chk("rec_count", 32'(cnt), 32'(e.cnt));
            end
        end
    end

    // Scoreboard for the 2-bit instance
    always @(negedge clk) begin
        if (reset && valid2 && rdy2) begin
            chk("sb2_nonempty", 32'(q2.size() != 0), 32'd1);
            if (q2.size() != 0) begin
                rec_t e;
                e = q2.pop_front();
                chk("rec2_src", 32'(src2), 32'(e.src));
                chk("rec2_count", 32'(cnt2), 32'(e.cnt));
            end
        end
    end

    initial begin
        reset = 1'b1;
        a = 1'b0; b = 1'b0; clr = 1'b0; rdy = 1'b1;
        a2 = 1'b0; b2 = 1'b0; clr2 = 1'b0; rdy2 = 1'b1;
        #1 reset = 1'b0;
        tick(3);

        // Reset state
        chk_out("rst", 1'b0, 1'b0, 8'd0);
        chk("rst_cnt_a", 32'(cnt_a), 32'd0);
        chk("rst_cnt_b", 32'(cnt_b), 32'd0);
        chk("rst_sat", 32'(sat), 32'd0);
        chk("rst_drop", 32'(drop), 32'd0);
        reset = 1'b1;
        tick(2);

        // Basic event: valid exactly one cycle, three edges after the first sample
        q.push_back(rec_t'{src: 1'b0, cnt: 8'd1});
        a = 1'b1;
        tick(3);
        chk("basic_early", 32'(valid), 32'd0);
        tick(1);
        chk_out("basic", 1'b1, 1'b0, 8'd1);
        chk("basic_cnt_a", 32'(cnt_a), 32'd1);
        tick(1);
        chk("basic_one_cycle", 32'(valid), 32'd0);
        a = 1'b0;
        tick(6);

        // Plain clear zeroes the counter
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("clr_cnt_a", 32'(cnt_a), 32'd0);

        // Backpressure: record held stable while ready is low
        rdy = 1'b0;
        q.push_back(rec_t'{src: 1'b0, cnt: 8'd1});
        a = 1'b1;
        tick(6);
        for (int i = 0; i < 3; i++) begin
            chk_out("bp_hold_a", 1'b1, 1'b0, 8'd1);
            tick(1);
        end
        q.push_back(rec_t'{src: 1'b1, cnt: 8'd1});
        b = 1'b1;
        tick(6);
        chk("bp_cnt_b", 32'(cnt_b), 32'd1);
        chk_out("bp_hold_a2", 1'b1, 1'b0, 8'd1);
        rdy = 1'b1;
        tick(1);
        rdy = 1'b0;
        chk_out("bp_next_b", 1'b1, 1'b1, 8'd1);
        tick(2);
        chk_out("bp_hold_b", 1'b1, 1'b1, 8'd1);
        // Second A event fills the empty slot A; a further one is dropped
        q.push_back(rec_t'{src: 1'b0, cnt: 8'd2});
        a = 1'b0;
        tick(6);
        a = 1'b1;
        tick(6);
        chk("bp_cnt_a2", 32'(cnt_a), 32'd2);
        chk("bp_no_drop", 32'(drop), 32'd0);
        a = 1'b0;
        tick(6);
        a = 1'b1;
        tick(6);
        chk("bp_cnt_a3", 32'(cnt_a), 32'd3);
        chk("bp_drop", 32'(drop), 32'd1);
        chk_out("bp_hold_b2", 1'b1, 1'b1, 8'd1);
        rdy = 1'b1;
        tick(4);
        chk("bp_drained", 32'(valid), 32'd0);

        // Clear in the same cycle as a detected rise
        a = 1'b0; b = 1'b0;
        tick(6);
        a = 1'b1;
        tick(2);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("clr_rise_cnt_a", 32'(cnt_a), 32'd0);
        chk("clr_rise_cnt_b", 32'(cnt_b), 32'd0);
        chk("clr_rise_drop", 32'(drop), 32'd0);
        chk("clr_rise_sat", 32'(sat), 32'd0);
        chk("clr_rise_valid", 32'(valid), 32'd0);
        tick(6);
        chk("clr_no_retrig_valid", 32'(valid), 32'd0);
        chk("clr_no_retrig_cnt", 32'(cnt_a), 32'd0);
        a = 1'b0;
        tick(6);

        // Simultaneous rises, round-robin order A,B / B,A / A,B
        for (int r = 1; r <= 3; r++) begin
            if (r == 2) begin
                q.push_back(rec_t'{src: 1'b1, cnt: 8'(r)});
                q.push_back(rec_t'{src: 1'b0, cnt: 8'(r)});
            end else begin
                q.push_back(rec_t'{src: 1'b0, cnt: 8'(r)});
                q.push_back(rec_t'{src: 1'b1, cnt: 8'(r)});
            end
            a = 1'b1; b = 1'b1;
            tick(6);
            chk("rr_cnt_a", 32'(cnt_a), 32'(r));
            chk("rr_cnt_b", 32'(cnt_b), 32'(r));
            a = 1'b0; b = 1'b0;
            tick(6);
        end
        chk("rr_drained", 32'(q.size()), 32'd0);

        // Asynchronous reset while FULL discards the record
        rdy = 1'b0;
        a = 1'b1;
        tick(6);
        chk("mr_full", 32'(valid), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk_out("mr", 1'b0, 1'b0, 8'd0);
        chk("mr_cnt_a", 32'(cnt_a), 32'd0);
        chk("mr_cnt_b", 32'(cnt_b), 32'd0);
        chk("mr_sat", 32'(sat), 32'd0);
        chk("mr_drop", 32'(drop), 32'd0);
        a = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(3);
        chk("mr_after", 32'(valid), 32'd0);

        // Saturation on the 2-bit instance
        for (int i = 1; i <= 7; i++) begin
            q2.push_back(rec_t'{src: 1'b0, cnt: 8'((i < 3) ? i : 3)});
            a2 = 1'b1;
            tick(6);
            if (i == 3) chk("sat_not_yet", 32'(sat2), 32'd0);
            if (i == 4) chk("sat_set", 32'(sat2), 32'd1);
            a2 = 1'b0;
            tick(6);
        end
        chk("sat_cnt_a", 32'(cnt_a2), 32'd3);
        chk("sat_flag", 32'(sat2), 32'd1);
        chk("sat_cnt_b", 32'(cnt_b2), 32'd0);
        chk("sat_drop", 32'(drop2), 32'd0);

        chk("sb_empty", 32'(q.size()), 32'd0);
        chk("sb2_empty", 32'(q2.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
